waveform_uart_tx: RTL
=====================

# waveform_uart_tx

Reads a captured waveform buffer (the 14-bit, trigger-aligned sample array produced by the DSP capture path) and streams it to the host over a UART 8N1 line. On a start request it walks the buffer from index 0 to N_SAMPLES-1 and emits each sample as two self-synchronising bytes. It sits between the capture path's waveform output and the board's UART TX pin.

## Interface
- N_SAMPLES, 1000: number of entries in waveform, and the number of samples sent per dump.
- CLKS_PER_BIT, 434: sys_clk cycles per UART bit (50 MHz / 115200). Must be ≥ 2.
- sys_clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle dump request; ignored while busy.
- waveform  in  14 × N_SAMPLES  unpacked array of unsigned samples; must be held stable while busy.
- tx  out  1  UART serial output, idle high.
- busy  out  1  high from the cycle after start is accepted until the dump ends.
- done  out  1  single-cycle pulse when the last stop bit completes.

## Operation
- Reset values: tx=1, busy=0, done=0. State is IDLE, sample index is 0, and the checksum is cleared.
- Byte encoding per sample s:
  - byte A = {1'b1, s[13:7]}, sent first.
  - byte B = {1'b0, s[6:0]}.
  - Bit 7 marks the first byte of each pair, so the host can resynchronise.
- Each byte is framed 8N1: one start bit (0), data bits LSB first, one stop bit (1). Every bit lasts exactly CLKS_PER_BIT cycles.
- State machine:
  - IDLE: start=1 → LOAD, and the index is cleared.
  - LOAD: registers waveform[index] and selects byte A → START.
  - START → DATA after one bit time.
  - DATA: 8 bits, bit counter 0..7 → STOP.
  - STOP, after one bit time:
    - if byte A was just sent → START with byte B;
    - else if index < N_SAMPLES-1 → index+1 and LOAD;
    - else → TRAILER (macro on) or DONE.
  - DONE: pulses done for 1 cycle, clears busy → IDLE.
- LOAD takes zero line time: tx stays high during LOAD, and the bit timer starts at START entry.
- Bytes are sent back to back. The only inter-byte gap is the single LOAD cycle before each byte A.
- Index counter width is clog2(N_SAMPLES). The index never wraps past N_SAMPLES-1.
- Simultaneous events:
  - start during busy is dropped; it is not queued.
  - start in the same cycle as the done pulse is also dropped, because the state is still DONE.
- Reset mid-operation: tx=1, busy=0 on the next cycle. No done pulse is produced. The partial byte is abandoned; the host discards it via the marker bit.

## Timing
- start sampled high in IDLE at edge t:
  - busy=1 and state=LOAD after edge t;
  - tx falls (start bit) after edge t+1.
- Byte A of sample k starts one cycle after the previous byte's stop bit ends. Byte B starts immediately, with no gap.
- Dump duration without the trailer: N_SAMPLES × (20·CLKS_PER_BIT + 1) cycles, from the LOAD entry to the end of the last stop bit.
- done is high for the cycle after the last stop bit completes. busy falls in that same cycle.
- waveform is read only in LOAD, one cycle before that sample's byte A start bit.

## Configuration
- WAVE_TX_CHECKSUM_EN defined:
  - A 14-bit running sum (mod 2^14) of all sent samples is accumulated in LOAD.
  - After the last sample, state TRAILER sends the sum as one more A/B pair with the same encoding, with no LOAD gap, then goes to DONE.
  - Duration grows by 20·CLKS_PER_BIT.
- Undefined: no accumulator or TRAILER state; STOP after the last byte B goes directly to DONE.

## Test plan
- Parameters for all scenarios: N_SAMPLES=4, CLKS_PER_BIT=4.
- Basic dump:
  - stimulus: waveform = {0x0000, 0x3FFF, 0x2A55, 0x0081}, pulse start.
  - required response: decoded bytes 0x80,0x00, 0xFF,0x7F, 0xD4,0x55, 0x81,0x01.
  - busy is high for exactly 4×81 = 324 cycles, then done pulses once.
- Bit timing:
  - each tx bit holds exactly 4 cycles;
  - the start bit appears 2 cycles after the start edge;
  - there is exactly a 1-cycle high gap before each byte A after the first.
- start while busy:
  - stimulus: pulse start mid-dump and again on the done cycle.
  - required response: byte stream identical to the basic dump; exactly one done; the module returns to IDLE with tx=1.
- Reset mid-byte:
  - stimulus: assert reset during byte B of sample 1.
  - required response: next cycle tx=1, busy=0, done never pulses.
  - a fresh start then sends the full sequence from sample 0.
- Checksum (WAVE_TX_CHECKSUM_EN):
  - stimulus: waveform = {0x3FFF, 0x0001, 0x0010, 0x0100}.
  - required response: sum = 0x0110, so the trailer bytes are 0x82,0x10.
  - busy lasts 324+80 = 404 cycles.

Source files
------------

// File: rtl/waveform_uart_tx.sv
// Streams a captured 14-bit waveform buffer over a UART 8N1 line, two marker-tagged bytes per sample.
// Optional feature: define WAVE_TX_CHECKSUM_EN to append a mod-2^14 sample sum as a trailing byte pair.
module waveform_uart_tx #(
   parameter int N_SAMPLES    = 1000,
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        sys_clk,
   input  logic        reset,
   input  logic        start,
   input  logic [13:0] waveform [N_SAMPLES],
   output logic        tx,
   output logic        busy,
   output logic        done
);

   localparam int IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
   localparam int TMR_W = $clog2(CLKS_PER_BIT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);
   localparam logic [TMR_W-1:0] LAST_TMR = TMR_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_DATA,
      S_STOP,
      S_DONE
   } state_t;

   state_t           state, next_state;
   logic [IDX_W-1:0] index;
   logic [TMR_W-1:0] timer;
   logic [2:0]       bit_cnt;
   logic [7:0]       byte_q;
   logic [6:0]       sample_lo;
   logic             byte_b;
   logic             trailer;
   logic             bit_end;
   logic             last_sample;

`ifdef WAVE_TX_CHECKSUM_EN
   logic [13:0] checksum;
`else
   assign trailer = 1'b0;
`endif

   assign bit_end     = (timer == LAST_TMR);
   assign last_sample = (index == LAST_IDX);

   // NOTE: synchronous reset -- reset is only looked at on the clock edge, like any other input.
   always_ff @(posedge sys_clk) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (start) next_state = S_LOAD;
         S_LOAD:  next_state = S_START;
         S_START: if (bit_end) next_state = S_DATA;
         S_DATA:  if (bit_end && bit_cnt == 3'd7) next_state = S_STOP;
         S_STOP: begin
            if (bit_end) begin
               if (!byte_b)           next_state = S_START;
               else if (trailer)      next_state = S_DONE;
               else if (!last_sample) next_state = S_LOAD;
`ifdef WAVE_TX_CHECKSUM_EN
               else                   next_state = S_START;
`else
               else                   next_state = S_DONE;
`endif
            end
         end
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      tx   = 1'b1;
      busy = 1'b0;
      done = 1'b0;
      case (state)
         S_LOAD:  busy = 1'b1;
         S_START: begin busy = 1'b1; tx = 1'b0; end
         S_DATA:  begin busy = 1'b1; tx = byte_q[bit_cnt]; end
         S_STOP:  busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         index     <= '0;
         timer     <= '0;
         bit_cnt   <= '0;
         byte_q    <= '0;
         sample_lo <= '0;
         byte_b    <= 1'b0;
`ifdef WAVE_TX_CHECKSUM_EN
         checksum  <= '0;
         trailer   <= 1'b0;
`endif
      end else begin
         // Bit timer runs only while a frame is on the line, so it restarts at every START entry.
         if (state == S_START || state == S_DATA || state == S_STOP)
            timer <= bit_end ? '0 : timer + 1'b1;
         else
            timer <= '0;

         if (state == S_DATA && bit_end)
            bit_cnt <= bit_cnt + 1'b1;

         case (state)
            S_IDLE: begin
               if (start) begin
                  index <= '0;
`ifdef WAVE_TX_CHECKSUM_EN
                  checksum <= '0;
                  trailer  <= 1'b0;
`endif
               end
            end
            S_LOAD: begin
               byte_q    <= {1'b1, waveform[index][13:7]};
               sample_lo <= waveform[index][6:0];
               byte_b    <= 1'b0;
`ifdef WAVE_TX_CHECKSUM_EN
               checksum  <= checksum + waveform[index];
`endif
            end
            S_STOP: begin
               if (bit_end) begin
                  if (!byte_b) begin
                     byte_b <= 1'b1;
`ifdef WAVE_TX_CHECKSUM_EN
                     byte_q <= {1'b0, trailer ? checksum[6:0] : sample_lo};
`else
                     byte_q <= {1'b0, sample_lo};
`endif
                  end else if (!trailer && !last_sample) begin
                     index <= index + 1'b1;
                  end
`ifdef WAVE_TX_CHECKSUM_EN
                  else if (!trailer) begin
                     trailer <= 1'b1;
                     byte_b  <= 1'b0;
                     byte_q  <= {1'b1, checksum[13:7]};
                  end
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule
